// File: rtl/axi_lite_adder_driver_if.sv
// AXI4-Lite bus bundle between the adder driver (master) and the axi-adder slave.
// Carries the five AXI4-Lite channels; clock and reset stay outside the bundle.
interface axi_lite_adder_driver_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_adder_driver.sv
// AXI4-Lite master that writes A and B into the axi-adder slave, reads back the sum
// and returns it with an error flag and a saturating latency count.
module axi_lite_adder_driver #(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_BASE_ADDR        = '0,
    parameter int                              C_CNT_WIDTH        = 16
) (
    input  logic                   m00_axi_aclk,
    input  logic                   m00_axi_reset,
    input  logic [31:0]            op_a,
    input  logic [31:0]            op_b,
    input  logic                   op_valid,
    output logic                   op_ready,
    output logic [31:0]            res_data,
    output logic                   res_err,
    output logic [C_CNT_WIDTH-1:0] res_cycles,
    output logic                   res_valid,
    input  logic                   res_ready,
    axi_lite_adder_driver_if.master m00_axi
);

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_A = C_BASE_ADDR;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_B = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_S = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WB_A,
        S_WR_B,
        S_WB_B,
        S_RD_S,
        S_WAIT_RD,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] op_b_q;
    logic        aw_done;
    logic        w_done;

    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign op_ready       = (state == S_IDLE) && !m00_axi_reset;
    assign m00_axi.awprot = 3'b000;
    assign m00_axi.arprot = 3'b000;
    assign m00_axi.wstrb  = '1;

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_reset) begin
            state           <= S_IDLE;
            op_b_q          <= '0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            m00_axi.awaddr  <= '0;
            m00_axi.awvalid <= 1'b0;
            m00_axi.wdata   <= '0;
            m00_axi.wvalid  <= 1'b0;
            m00_axi.bready  <= 1'b0;
            m00_axi.araddr  <= '0;
            m00_axi.arvalid <= 1'b0;
            m00_axi.rready  <= 1'b0;
            res_data        <= '0;
            res_err         <= 1'b0;
            res_cycles      <= '0;
            res_valid       <= 1'b0;
        end else begin
            // Latency counts every cycle spent on the bus, including the edge that enters DONE.
            if (state != S_IDLE && state != S_DONE)
                res_cycles <= sat_inc(res_cycles);

            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_b_q          <= op_b;
                        m00_axi.awaddr  <= ADDR_A;
                        m00_axi.wdata   <= op_a;
                        m00_axi.awvalid <= 1'b1;
                        m00_axi.wvalid  <= 1'b1;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                        res_err         <= 1'b0;
                        res_data        <= '0;
                        res_cycles      <= '0;
                        state           <= S_WR_A;
                    end
                end

                S_WR_A, S_WR_B: begin
                    // AW and W complete independently; each valid drops right after its own beat.
                    if (m00_axi.awvalid && m00_axi.awready) begin
                        m00_axi.awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (m00_axi.wvalid && m00_axi.wready) begin
                        m00_axi.wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if (aw_done && w_done) begin
                        m00_axi.bready <= 1'b1;
                        state          <= (state == S_WR_A) ? S_WB_A : S_WB_B;
                    end
                end

                S_WB_A, S_WB_B: begin
                    if (m00_axi.bvalid) begin
                        m00_axi.bready <= 1'b0;
                        if (m00_axi.bresp != 2'b00) begin
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (state == S_WB_A) begin
                            m00_axi.awaddr  <= ADDR_B;
                            m00_axi.wdata   <= op_b_q;
                            m00_axi.awvalid <= 1'b1;
                            m00_axi.wvalid  <= 1'b1;
                            aw_done         <= 1'b0;
                            w_done          <= 1'b0;
                            state           <= S_WR_B;
                        end else begin
                            m00_axi.araddr  <= ADDR_S;
                            m00_axi.arvalid <= 1'b1;
                            state           <= S_RD_S;
                        end
                    end
                end

                S_RD_S: begin
                    if (m00_axi.arready) begin
                        m00_axi.arvalid <= 1'b0;
                        m00_axi.rready  <= 1'b1;
                        state           <= S_WAIT_RD;
                    end
                end

                S_WAIT_RD: begin
                    if (m00_axi.rvalid) begin
                        m00_axi.rready <= 1'b0;
                        res_data       <= m00_axi.rdata;
                        if (m00_axi.rresp != 2'b00)
                            res_err <= 1'b1;
                        res_valid      <= 1'b1;
                        state          <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
